// File: rtl/adpll_seq.sv
// ADPLL sequencer: takes channel requests, walks adpll_ctr0 through reset, enable and lock
// acquisition with timeout, and serialises TX payload words onto data_mod at a fixed symbol rate.
module adpll_seq #(
  parameter int unsigned FCWW    = 26,
  parameter int unsigned RST_CYC = 4,
  parameter int unsigned LOCK_TO = 4096,
  parameter int unsigned SYM_CYC = 32,
  parameter int unsigned DATAW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [FCWW-1:0]  req_fcw,
  input  logic [1:0]       req_mode,
  input  logic             stop,
  input  logic             channel_lock,
  output logic             adpll_rst,
  output logic             adpll_en,
  output logic [1:0]       adpll_mode,
  output logic [FCWW-1:0]  adpll_fcw,
  input  logic             tx_valid,
  input  logic [DATAW-1:0] tx_data,
  output logic             tx_ready,
  output logic             data_mod,
  output logic             busy,
  output logic             locked,
  output logic             lock_err
);

  localparam logic [1:0] ModePd   = 2'd0;
  localparam logic [1:0] ModeTest = 2'd1;
  localparam logic [1:0] ModeTx   = 2'd3;

  localparam int unsigned CntMax = (LOCK_TO > RST_CYC) ? LOCK_TO : RST_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned SymW   = $clog2(SYM_CYC + 1);
  localparam int unsigned BitW   = $clog2(DATAW + 1);

  localparam logic [CntW-1:0] RstLast  = CntW'(RST_CYC - 1);
  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_TO - 1);
  localparam logic [SymW-1:0] SymLast  = SymW'(SYM_CYC - 1);
  localparam logic [BitW-1:0] BitsFull = BitW'(DATAW);

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StLock,
    StActive,
    StShutdown
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [FCWW-1:0]  fcw_d;
  logic [1:0]       mode_d;
  logic             lock_err_d;
  logic             lock_ok;

  logic [DATAW-1:0] sh_q, sh_d;
  logic [BitW-1:0]  bits_q, bits_d;
  logic [SymW-1:0]  sym_q, sym_d;
  logic             data_mod_d;
  logic             tx_ready_d;

  // Session control
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    fcw_d      = adpll_fcw;
    mode_d     = adpll_mode;
    lock_err_d = lock_err;
    lock_ok    = (adpll_mode == ModeTest) || channel_lock;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          fcw_d      = req_fcw;
          mode_d     = req_mode;
          lock_err_d = 1'b0;
          if (req_mode != ModePd) state_d = StReset;
        end
      end
      StReset: begin
        if (stop) begin
          state_d = StShutdown;
        end else if (cnt_q == RstLast) begin
          state_d = StLock;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLock: begin
        // A timeout still flags the error when stop arrives on the same cycle
        if (!lock_ok && (cnt_q == LockLast)) begin
          lock_err_d = 1'b1;
          state_d    = StShutdown;
        end else if (stop) begin
          state_d = StShutdown;
        end else if (lock_ok) begin
          state_d = StActive;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StActive: begin
        if (stop) state_d = StShutdown;
      end
      StShutdown: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // TX serialiser; only live while the next state is ACTIVE in TX mode
  always_comb begin
    sh_d       = sh_q;
    bits_d     = bits_q;
    sym_d      = sym_q;
    data_mod_d = data_mod;

    if ((state_d != StActive) || (adpll_mode != ModeTx)) begin
      sh_d       = '0;
      bits_d     = '0;
      sym_d      = '0;
      data_mod_d = 1'b0;
    end else if (tx_valid && tx_ready) begin
      sh_d       = tx_data;
      bits_d     = BitsFull;
      sym_d      = '0;
      data_mod_d = tx_data[DATAW-1];
    end else if (bits_q != '0) begin
      if (sym_q == SymLast) begin
        sym_d = '0;
        if (bits_q == BitW'(1)) begin
          bits_d = '0;
        end else begin
          sh_d       = {sh_q[DATAW-2:0], 1'b0};
          bits_d     = bits_q - 1'b1;
          data_mod_d = sh_q[DATAW-2];
        end
      end else begin
        sym_d = sym_q + 1'b1;
      end
    end

    // Ready also in the last cycle of the final bit so the next word follows without a gap
    tx_ready_d = (state_d == StActive) && (adpll_mode == ModeTx) &&
                 ((bits_d == '0) || ((bits_d == BitW'(1)) && (sym_d == SymLast)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sh_q       <= '0;
      bits_q     <= '0;
      sym_q      <= '0;
      adpll_rst  <= 1'b0;
      adpll_en   <= 1'b0;
      adpll_mode <= '0;
      adpll_fcw  <= '0;
      data_mod   <= 1'b0;
      tx_ready   <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      locked     <= 1'b0;
      lock_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      bits_q     <= bits_d;
      sym_q      <= sym_d;
      adpll_rst  <= (state_d == StReset);
      adpll_en   <= (state_d == StLock) || (state_d == StActive);
      adpll_mode <= mode_d;
      adpll_fcw  <= fcw_d;
      data_mod   <= data_mod_d;
      tx_ready   <= tx_ready_d;
      req_ready  <= (state_d == StIdle);
      busy       <= (state_d != StIdle);
      locked     <= (state_d == StActive);
      lock_err   <= lock_err_d;
    end
  end

endmodule

// File: tb/tb_adpll_seq.sv
// Self-checking bench for adpll_seq: table of session scenarios plus hand-written TX,
// stop and reset sequences, with queued expectations compared as the DUT produces them.
module tb_adpll_seq;

  localparam int unsigned FCWW    = 26;
  localparam int unsigned RST_CYC = 4;
  localparam int unsigned LOCK_TO = 4096;
  localparam int unsigned SYM_CYC = 32;
  localparam int unsigned DATAW   = 8;

  localparam logic [1:0] ModePd   = 2'd0;
  localparam logic [1:0] ModeTest = 2'd1;
  localparam logic [1:0] ModeRx   = 2'd2;
  localparam logic [1:0] ModeTx   = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [FCWW-1:0]  req_fcw;
  logic [1:0]       req_mode;
  logic             stop;
  logic             channel_lock;
  logic             adpll_rst;
  logic             adpll_en;
  logic [1:0]       adpll_mode;
  logic [FCWW-1:0]  adpll_fcw;
  logic             tx_valid;
  logic [DATAW-1:0] tx_data;
  logic             tx_ready;
  logic             data_mod;
  logic             busy;
  logic             locked;
  logic             lock_err;

  always #5 clk = ~clk;

  adpll_seq #(
    .FCWW   (FCWW),
    .RST_CYC(RST_CYC),
    .LOCK_TO(LOCK_TO),
    .SYM_CYC(SYM_CYC),
    .DATAW  (DATAW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_fcw     (req_fcw),
    .req_mode    (req_mode),
    .stop        (stop),
    .channel_lock(channel_lock),
    .adpll_rst   (adpll_rst),
    .adpll_en    (adpll_en),
    .adpll_mode  (adpll_mode),
    .adpll_fcw   (adpll_fcw),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .data_mod    (data_mod),
    .busy        (busy),
    .locked      (locked),
    .lock_err    (lock_err)
  );

  typedef struct {
    logic [1:0]      mode;
    logic [FCWW-1:0] fcw;
    int              lock_at;   // LOCK cycle where channel_lock rises; -1 never
    int              stop_at;   // LOCK cycle where stop rises; -1 never
    int              exp_rst;   // cycles with adpll_rst high
    int              exp_lock;  // cycles spent in LOCK
    bit              exp_ok;    // session reaches ACTIVE
    bit              exp_err;   // lock_err afterwards
  } vec_t;

  localparam int NumVec = 8;
  vec_t vecs[NumVec];
  vec_t sb[$];
  bit   bitq[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] out_vec();
    return {adpll_rst, adpll_en, adpll_mode, adpll_fcw, data_mod, tx_ready, req_ready, busy,
            locked, lock_err};
  endfunction

  localparam logic [35:0] ResetOuts = 36'h8;  // only req_ready high

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [DATAW-1:0] w);
    for (int b = DATAW - 1; b >= 0; b--) bitq.push_back(w[b]);
  endtask

  // Issues a request and follows it until ACTIVE or back in IDLE. Returns at the first ACTIVE
  // sample (ok=1) or the first IDLE sample afterwards.
  task automatic run_session(input logic [1:0] mode, input logic [FCWW-1:0] fcw,
                             input int lock_at, input int stop_at,
                             output int rst_cyc, output int lock_cyc, output bit ok,
                             output bit err_sd, output bit done);
    rst_cyc  = 0;
    lock_cyc = 0;
    ok       = 1'b0;
    err_sd   = 1'b0;
    done     = 1'b0;
    req_valid = 1'b1;
    req_fcw   = fcw;
    req_mode  = mode;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < int'(LOCK_TO) + 64; i++) begin
      if (locked) begin
        ok   = 1'b1;
        done = 1'b1;
        break;
      end else if (adpll_rst) begin
        rst_cyc++;
      end else if (adpll_en) begin
        if (lock_cyc == lock_at) channel_lock = 1'b1;
        if (lock_cyc == stop_at) stop = 1'b1;
        lock_cyc++;
      end else if (busy) begin
        err_sd = lock_err;
        stop   = 1'b0;
      end else begin
        done = 1'b1;
        break;
      end
      tick();
    end
  endtask

  int   r_cyc, l_cyc;
  bit   s_ok, s_err, s_done;
  vec_t e;
  bit   cur;

  initial begin
    vecs[0] = '{ModeRx,   26'd40632320, 100,  -1,   4, 101,  1'b1, 1'b0};
    vecs[1] = '{ModeTest, 26'd123,      -1,   -1,   4, 1,    1'b1, 1'b0};
    vecs[2] = '{ModeTx,   26'h2AAAAAA,  0,    -1,   4, 1,    1'b1, 1'b0};
    vecs[3] = '{ModeRx,   26'd777,      -1,   -1,   4, 4096, 1'b0, 1'b1};
    vecs[4] = '{ModePd,   26'd555,      -1,   -1,   0, 0,    1'b0, 1'b0};
    vecs[5] = '{ModeRx,   26'd999,      -1,   5,    4, 6,    1'b0, 1'b0};
    vecs[6] = '{ModeTx,   26'd1000,     -1,   4095, 4, 4096, 1'b0, 1'b1};
    vecs[7] = '{ModeRx,   26'd4242,     4095, -1,   4, 4096, 1'b1, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_fcw = '0; req_mode = '0; stop = 1'b0;
    channel_lock = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tick();
    tick();
    check("reset_outputs", out_vec(), ResetOuts);
    rst = 1'b0;
    tick();

    // Session scenarios
    for (int v = 0; v < NumVec; v++) begin
      sb.push_back(vecs[v]);
      run_session(vecs[v].mode, vecs[v].fcw, vecs[v].lock_at, vecs[v].stop_at,
                  r_cyc, l_cyc, s_ok, s_err, s_done);
      e = sb.pop_front();
      check("session_bound", s_done, 1'b1);
      check("rst_cycles", r_cyc, e.exp_rst);
      check("lock_cycles", l_cyc, e.exp_lock);
      check("reached_active", s_ok, e.exp_ok);
      check("fcw", adpll_fcw, e.fcw);
      check("mode", adpll_mode, e.mode);
      if (e.exp_ok) begin
        check("active_en", adpll_en, 1'b1);
        check("active_tx_ready", tx_ready, e.mode == ModeTx);
        check("active_data_mod", data_mod, 1'b0);
        channel_lock = 1'b0;
        tick();
        check("lock_drop_hold", locked, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("shutdown_en", adpll_en, 1'b0);
        check("shutdown_busy", busy, 1'b1);
        tick();
        check("idle_busy", busy, 1'b0);
        check("idle_req_ready", req_ready, 1'b1);
        check("idle_fcw_kept", adpll_fcw, e.fcw);
      end else begin
        check("err_at_shutdown", s_err, e.exp_err);
        check("lock_err", lock_err, e.exp_err);
        check("idle_en", adpll_en, 1'b0);
        check("idle_busy", busy, 1'b0);
      end
      channel_lock = 1'b0;
      stop = 1'b0;
    end

    // TX stream: two back-to-back words
    run_session(ModeTx, 26'd40632320, 0, -1, r_cyc, l_cyc, s_ok, s_err, s_done);
    check("tx_session_up", s_ok, 1'b1);
    check("tx_ready_first", tx_ready, 1'b1);
    channel_lock = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    push_word(8'hA5);
    tick();
    tx_data = 8'h3C;
    push_word(8'h3C);
    for (int i = 0; i < 16 * int'(SYM_CYC); i++) begin
      if (i == 8 * int'(SYM_CYC)) tx_valid = 1'b0;
      if (i % int'(SYM_CYC) == 0) cur = bitq.pop_front();
      check("tx_bit", data_mod, cur);
      check("tx_ready_edge", tx_ready, (i % (8 * int'(SYM_CYC))) == 8 * int'(SYM_CYC) - 1);
      tick();
    end
    check("tx_empty_ready", tx_ready, 1'b1);
    check("tx_empty_hold0", data_mod, 1'b0);

    // Empty register holds last bit, then stop mid-symbol
    tx_valid = 1'b1;
    tx_data  = 8'h01;
    tick();
    tx_valid = 1'b0;
    repeat (8 * SYM_CYC) tick();
    check("hold_last_bit", data_mod, 1'b1);
    check("hold_ready", tx_ready, 1'b1);
    tick();
    check("hold_last_bit2", data_mod, 1'b1);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    repeat (3 * SYM_CYC + 10) tick();
    check("pre_stop_bit", data_mod, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_data_mod", data_mod, 1'b0);
    check("stop_en", adpll_en, 1'b0);
    check("stop_busy", busy, 1'b1);
    check("stop_locked", locked, 1'b0);
    tick();
    check("stop_idle_data_mod", data_mod, 1'b0);
    check("stop_idle_en", adpll_en, 1'b0);
    check("stop_idle_busy", busy, 1'b0);
    check("stop_idle_tx_ready", tx_ready, 1'b0);

    // Reset mid-LOCK
    req_valid = 1'b1;
    req_fcw   = 26'd40632320;
    req_mode  = ModeRx;
    tick();
    req_valid = 1'b0;
    repeat (RST_CYC + 10) tick();
    check("mid_lock_en", adpll_en, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_mid_lock", out_vec(), ResetOuts);
    tick();
    check("reset_mid_lock_idle", busy, 1'b0);

    // Reset mid-TX
    run_session(ModeTx, 26'd31337, 3, -1, r_cyc, l_cyc, s_ok, s_err, s_done);
    check("tx2_session_up", s_ok, 1'b1);
    channel_lock = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    repeat (40) tick();
    check("mid_tx_data_mod", data_mod, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_mid_tx", out_vec(), ResetOuts);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adpll_seq.md
Name: adpll_seq

Overview:
Sequencer for the ADPLL controller (adpll_ctr0). It accepts channel requests carrying FCW and operating mode, then drives the ADPLL through soft reset, enable and lock acquisition, with a lock timeout. In TX it serialises payload words onto data_mod at a fixed symbol rate. It sits between the host register interface and adpll_ctr0 and replaces manual sequencing of rst, en, adpll_mode and FCW.

Parameters:
FCWW, 26, FCW width in bits (Q.14 MHz word; 2480 MHz is 40632320)
RST_CYC, 4, cycles adpll_rst is held high
LOCK_TO, 4096, max cycles in LOCK waiting for channel_lock
SYM_CYC, 32, clk cycles per TX data bit
DATAW, 8, TX payload word width

Ports:
clk  in  1  system clock (32 MHz)
rst  in  1  synchronous reset, active-high
req_valid  in  1  channel request valid
req_ready  out  1  request accepted when req_valid&req_ready
req_fcw  in  FCWW  requested channel FCW
req_mode  in  2  requested mode: PD=0, TEST=1, RX=2, TX=3
stop  in  1  level; ends active session
channel_lock  in  1  lock indication from adpll_ctr0
adpll_rst  out  1  reset to adpll_ctr0
adpll_en  out  1  enable to adpll_ctr0
adpll_mode  out  2  mode to adpll_ctr0
adpll_fcw  out  FCWW  FCW to adpll_ctr0
tx_valid  in  1  TX payload word valid
tx_data  in  DATAW  TX payload word, sent MSB first
tx_ready  out  1  word accepted when tx_valid&tx_ready
data_mod  out  1  modulation bit to adpll_ctr0
busy  out  1  high in every state except IDLE
locked  out  1  high in ACTIVE only
lock_err  out  1  sticky timeout flag, cleared on next accepted request

Behaviour:
- Reset state on rst=1, synchronous: state IDLE; adpll_rst=0, adpll_en=0, adpll_mode=0, adpll_fcw=0, data_mod=0, tx_ready=0, req_ready=1, busy=0, locked=0, lock_err=0; all counters=0. rst has priority over every other input.
- States: IDLE, RESET, LOCK, ACTIVE, SHUTDOWN.
- IDLE: req_ready=1. On a request handshake, register req_fcw into adpll_fcw and req_mode into adpll_mode, clear lock_err, and go to RESET next cycle.
  - req_mode=PD: register fields, stay in IDLE; en stays 0.
- RESET: adpll_rst=1 for exactly RST_CYC cycles, then go to LOCK with adpll_rst=0 and adpll_en=1 on the same edge.
- LOCK: adpll_en=1. Count cycles from 0.
  - TEST mode: bypass the lock wait; go to ACTIVE after 1 cycle.
  - RX/TX: channel_lock=1 sampled at count c goes to ACTIVE next cycle.
  - Count reaching LOCK_TO-1 without lock: set lock_err=1 and go to SHUTDOWN.
- ACTIVE: locked=1, adpll_en=1.
  - stop=1 goes to SHUTDOWN next cycle, even mid-symbol; data_mod returns to 0.
  - channel_lock dropping in ACTIVE does not change state (adpll_ctr0 holds lock internally).
- TX shifter (ACTIVE and mode=TX only):
  - tx_ready=1 when the shift register is empty.
  - On handshake, load tx_data. data_mod = tx_data[DATAW-1] from the next cycle.
  - Each bit is held SYM_CYC cycles; after DATAW bits the register is empty.
  - Back-to-back words: tx_ready rises in the last cycle of the final bit, so a word accepted then gives continuous bits with no gap.
  - When empty, data_mod holds the last bit value.
  - In non-TX modes tx_ready=0 and data_mod=0.
- SHUTDOWN: adpll_en=0 and data_mod=0 for one cycle, then IDLE. The shifter is discarded; adpll_fcw and adpll_mode are retained.
- req_valid outside IDLE is ignored (req_ready=0). A new request during ACTIVE requires stop first.
- stop in RESET or LOCK goes to SHUTDOWN next cycle and does not set lock_err.
- stop and timeout on the same cycle: SHUTDOWN with lock_err=1.
- All outputs are registered; no combinational input-to-output paths except none.

Test Plan:
- RX lock: req FCW=40632320, mode=2; channel_lock=1 at LOCK cycle 100 -> adpll_rst high 4 cycles, en=1 from then on, locked=1 at LOCK cycle 101, adpll_fcw=40632320.
- Timeout: mode=2, channel_lock held 0 -> lock_err=1 after 4096 LOCK cycles, en=0 one cycle later, state IDLE; next request clears lock_err.
- TX stream: mode=3, locked; words 0xA5 then 0x3C back-to-back -> data_mod is 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, each bit 32 cycles, no gap between words.
- Stop mid-symbol: stop at bit 3 cycle 10 -> data_mod=0 and en=0 on the next two edges, busy=0 after SHUTDOWN.
- TEST/PD modes: mode=1 -> ACTIVE without waiting for channel_lock, tx_ready=0; mode=0 -> remains IDLE, en=0.
- Reset mid-LOCK and mid-TX: rst=1 for 1 cycle -> all outputs at reset values on the following edge.
